// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a Wishbone register pair (TXDR/TXCSR).
// Sends one byte per TXDR write using the host request-to-send sequence,
// checks the device acknowledge and reports completion through READY/ERR/irq.
module ps2_tx #(
    parameter int CLKFREQ     = 50000000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_US = 15000,
    parameter int FRAME_TO_US = 2000,
    parameter int FILT        = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        busy
);

    localparam int          CYC_PER_US = CLKFREQ / 1000000;
    localparam logic [31:0] INH_CYC    = 32'(INHIBIT_US * CYC_PER_US);
    localparam logic [31:0] START_CYC  = 32'(START_TO_US * CYC_PER_US);
    localparam logic [31:0] FRAME_CYC  = 32'(FRAME_TO_US * CYC_PER_US);
    localparam int          FW         = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_STARTBIT, S_START, S_SEND, S_ACK, S_WAITIDLE, S_FINISH
    } state_t;

    // Odd parity bit for a byte: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t      state, state_n;
    logic [31:0] tmr, tmr_n;
    logic [3:0]  bit_n, bit_n_n;
    logic        data_oe, data_oe_n;
    logic        err_evt;

    logic        clk_sync_p0, clk_sync_p1, data_sync_p0, data_sync_p1;
    logic        clk_f, data_f, clk_f_d, fall;
    logic [FW-1:0] clk_cnt, data_cnt;

    logic [7:0]  txdr;
    logic        ready, ie, err, ack, req_seen;
    logic        req, wr_first, wr_txdr, wr_csr, tx_go;
    logic        irq_set, irq_clr;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[14:8], wb_sel_i[1]};

    // Two-flop synchronizers followed by the consecutive-sample glitch filters
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
            clk_f        <= 1'b1;
            data_f       <= 1'b1;
            clk_f_d      <= 1'b1;
            clk_cnt      <= '0;
            data_cnt     <= '0;
        end else begin
            clk_sync_p0  <= ps2_clk_i;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data_i;
            data_sync_p1 <= data_sync_p0;
            clk_f_d      <= clk_f;
            if (clk_sync_p1 == clk_f) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILT - 1)) begin
                clk_f   <= clk_sync_p1;
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + FW'(1);
            end
            if (data_sync_p1 == data_f) begin
                data_cnt <= '0;
            end else if (data_cnt == FW'(FILT - 1)) begin
                data_f   <= data_sync_p1;
                data_cnt <= '0;
            end else begin
                data_cnt <= data_cnt + FW'(1);
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // Bus decode: a write acts only on the first cycle of a strobe
    assign req      = wb_cyc_i & wb_stb_i;
    assign wr_first = req & ~req_seen & wb_we_i;
    assign wr_txdr  = wr_first & ~wb_adr_i[1];
    assign wr_csr   = wr_first & wb_adr_i[1];
    assign tx_go    = wr_txdr & wb_sel_i[0] & ready;

    // Registered single-cycle acknowledge per strobe
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack      <= 1'b0;
            req_seen <= 1'b0;
        end else begin
            ack      <= req & ~req_seen;
            req_seen <= req;
        end
    end

    assign wb_ack_o = ack;
    assign wb_dat_o = wb_adr_i[1] ? {err, 7'b0, ready, ie, 6'b0} : {8'b0, txdr};

    // Frame sequencer next-state, bit presentation and timeout decisions
    always_comb begin
        state_n   = state;
        tmr_n     = tmr + 32'd1;
        bit_n_n   = bit_n;
        data_oe_n = data_oe;
        err_evt   = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_n = '0;
                if (tx_go) state_n = S_INHIBIT;
            end
            S_INHIBIT: begin
                // Last inhibit cycle overlaps the start bit, so clock is held INH_CYC in total
                if (tmr == INH_CYC - 32'd2) begin
                    data_oe_n = 1'b1;
                    state_n   = S_STARTBIT;
                end
            end
            S_STARTBIT: begin
                tmr_n   = '0;
                state_n = S_START;
            end
            S_START: begin
                if (fall) begin
                    data_oe_n = ~txdr[0];
                    bit_n_n   = 4'd1;
                    tmr_n     = '0;
                    state_n   = S_SEND;
                end else if (tmr == START_CYC - 32'd1) begin
                    err_evt   = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = S_FINISH;
                end
            end
            S_SEND: begin
                if (tmr == FRAME_CYC - 32'd1) begin
                    err_evt   = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = S_FINISH;
                end else if (fall) begin
                    if (bit_n < 4'd8) begin
                        data_oe_n = ~txdr[bit_n[2:0]];
                        bit_n_n   = bit_n + 4'd1;
                    end else if (bit_n == 4'd8) begin
                        data_oe_n = ~odd_parity(txdr);
                        bit_n_n   = 4'd9;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (tmr == FRAME_CYC - 32'd1) begin
                    err_evt   = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = S_FINISH;
                end else if (fall) begin
                    err_evt = data_f;
                    state_n = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                if (tmr == FRAME_CYC - 32'd1) begin
                    err_evt   = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = S_FINISH;
                end else if (clk_f && data_f) begin
                    state_n = S_FINISH;
                end
            end
            S_FINISH: begin
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    // Frame sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_n   <= '0;
            data_oe <= 1'b0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            bit_n   <= bit_n_n;
            data_oe <= data_oe_n;
        end
    end

    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_STARTBIT);
    assign ps2_data_oe = data_oe;

    assign irq_set = ((state == S_FINISH) && ie) ||
                     (wr_csr && wb_sel_i[0] && wb_dat_i[6] && !ie && ready);
    assign irq_clr = iack || (wr_csr && wb_sel_i[0] && !wb_dat_i[6]) || tx_go;

    // Status bits, data register and interrupt request; set events win over clears
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            txdr  <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            ie    <= 1'b0;
            err   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (tx_go) begin
                txdr  <= wb_dat_i[7:0];
                ready <= 1'b0;
                busy  <= 1'b1;
                err   <= 1'b0;
            end
            if (state_n == S_FINISH) busy <= 1'b0;
            if (state == S_FINISH) ready <= 1'b1;
            if (wr_csr) begin
                if (wb_sel_i[0]) ie <= wb_dat_i[6];
                if (!wb_dat_i[15]) err <= 1'b0;
            end
            if (err_evt) err <= 1'b1;
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device drives the open-drain lines,
// captured frames are compared with a byte-to-frame reference function.
module tb_ps2_tx;

    localparam int CLKF = 1000000;
    localparam int H    = 40;
    localparam int INH  = 100;

    typedef struct {
        logic [7:0]  data;
        int          nclk;
        bit          dev_ack;
        logic [15:0] exp_csr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr, dat_i, dat_o;
    logic        cyc, stb, we, ack, irq, iack;
    logic [1:0]  sel;
    logic        clk_line, data_line, clk_oe, data_oe, busy;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        vecs[6];

    always #5 clk = ~clk;

    assign clk_line  = ~(clk_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);

    ps2_tx #(.CLKFREQ(CLKF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_ack_o(ack), .irq(irq), .iack(iack),
        .ps2_clk_i(clk_line), .ps2_data_i(data_line),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line bits after the start bit: data LSB first, odd parity, stop
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = ($countones(b) % 2 == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic wb_write(input bit csr, input logic [15:0] d, input logic [1:0] s, input bit with_iack);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = csr ? 16'h0002 : 16'h0000;
        dat_i = d; sel = s; iack = with_iack;
        @(posedge clk); #1;
        iack = 1'b0;
        check("wb_write_ack", ack, 1'b1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input bit csr, output logic [15:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = csr ? 16'h0002 : 16'h0000;
        #1 d = dat_o;
        @(posedge clk); #1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic pulse_iack();
        @(negedge clk); iack = 1'b1;
        @(negedge clk); iack = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int c;
        c = 0;
        while (busy && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("frame_done_in_time", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Behavioural PS/2 device: measures inhibit, clocks nclk bits, samples on rising edges
    task automatic dev_frame(input int nclk, input bit do_ack, output logic [9:0] bits,
                             output int inh_len, output logic start_bit);
        int w;
        bits = '0; inh_len = 0; w = 0;
        while (!clk_oe && w < 50) begin
            @(negedge clk);
            w++;
        end
        while (clk_oe && inh_len < 20000) begin
            @(negedge clk);
            inh_len++;
        end
        start_bit = data_line;
        repeat (30) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            if (i < 10) bits[i] = data_line;
            repeat (H - 2) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_tx(input logic [7:0] b, input int nclk, input bit do_ack,
                          input logic [15:0] exp_csr, input string tag);
        logic [9:0]  bits;
        int          inh;
        logic        sb;
        logic [15:0] rd;
        fork
            dev_frame(nclk, do_ack, bits, inh, sb);
            begin
                wb_write(1'b0, {8'h00, b}, 2'b01, 1'b0);
                check($sformatf("%s_busy_set", tag), busy, 1'b1);
                check($sformatf("%s_irq_start_clear", tag), irq, 1'b0);
                wb_read(1'b1, rd);
                check($sformatf("%s_rdy_err_low", tag), rd & 16'h8080, 16'h0000);
            end
        join
        wait_done(3000);
        check($sformatf("%s_inhibit_len", tag), inh, INH);
        check($sformatf("%s_start_bit", tag), sb, 1'b0);
        if (nclk == 11) check($sformatf("%s_frame_bits", tag), bits, ref_frame(b));
        wb_read(1'b1, rd);
        check($sformatf("%s_csr", tag), rd, exp_csr);
        wb_read(1'b0, rd);
        check($sformatf("%s_txdr", tag), rd, {8'h00, b});
        check($sformatf("%s_lines_idle", tag), {clk_oe, data_oe, busy}, 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [9:0]  bits;
        int          inh, cnt;
        logic        sb, a0, a1, a2;
        logic [7:0]  rb;
        bit          rack;

        vecs[0] = '{8'hED, 11, 1'b1, 16'h0080};
        vecs[1] = '{8'h00, 11, 1'b1, 16'h0080};
        vecs[2] = '{8'h01, 11, 1'b1, 16'h0080};
        vecs[3] = '{8'hF4, 11, 1'b1, 16'h0080};
        vecs[4] = '{8'hAA, 11, 1'b0, 16'h8080};
        vecs[5] = '{8'h55, 5,  1'b1, 16'h8080};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0; iack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", {clk_oe, data_oe, busy, irq, ack}, 5'b00000);
        wb_read(1'b1, rd);
        check("rst_csr", rd, 16'h0080);
        wb_read(1'b0, rd);
        check("rst_txdr", rd, 16'h0000);

        // Acknowledge is a single pulse even when the strobe is held
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0002;
        @(posedge clk); #1 a0 = ack;
        @(posedge clk); #1 a1 = ack;
        @(posedge clk); #1 a2 = ack;
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        check("ack_single_pulse", {a0, a1, a2}, 3'b100);

        for (int i = 0; i < 6; i++)
            run_tx(vecs[i].data, vecs[i].nclk, vecs[i].dev_ack, vecs[i].exp_csr, $sformatf("vec%0d", i));

        // Write while busy is ignored
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        fork
            dev_frame(11, 1'b1, bits, inh, sb);
            begin
                wb_write(1'b0, 16'h0000, 2'b01, 1'b0);
                repeat (300) @(negedge clk);
                wb_write(1'b0, 16'h0001, 2'b01, 1'b0);
                wb_read(1'b0, rd);
                check("busy_write_ignored", rd, 16'h0000);
                check("busy_still_set", busy, 1'b1);
            end
        join
        wait_done(3000);
        check("busy_frame_bits", bits, ref_frame(8'h00));
        wb_read(1'b0, rd);
        check("busy_txdr_after", rd, 16'h0000);

        // Interrupt behaviour
        wb_write(1'b1, 16'h0040, 2'b01, 1'b0);
        check("irq_ie_rise", irq, 1'b1);
        pulse_iack();
        check("irq_iack_clear", irq, 1'b0);
        wb_write(1'b1, 16'h0040, 2'b01, 1'b0);
        check("irq_ie_already_set", irq, 1'b0);
        run_tx(8'hFF, 11, 1'b1, 16'h00C0, "ie_ff");
        check("irq_on_finish", irq, 1'b1);
        pulse_iack();
        check("irq_iack_after_finish", irq, 1'b0);
        wb_write(1'b1, 16'h0000, 2'b01, 1'b0);
        wb_write(1'b1, 16'h0040, 2'b01, 1'b1);
        check("irq_set_beats_iack", irq, 1'b1);
        wb_write(1'b1, 16'h0000, 2'b01, 1'b0);
        check("irq_clear_by_ie0", irq, 1'b0);

        // Device never clocks: start timeout
        wb_write(1'b0, 16'h0012, 2'b01, 1'b0);
        cnt = 0;
        while (busy && cnt < 16000) begin
            @(negedge clk);
            cnt++;
        end
        check("start_to_cycles_in_range", (cnt >= 15095 && cnt <= 15110), 1'b1);
        repeat (2) @(negedge clk);
        check("start_to_lines", {clk_oe, data_oe, busy}, 3'b000);
        wb_read(1'b1, rd);
        check("start_to_csr", rd, 16'h8080);
        wb_write(1'b1, 16'h0000, 2'b01, 1'b0);
        wb_read(1'b1, rd);
        check("err_clear_by_csr", rd, 16'h0080);

        // Reset in the middle of a frame
        wb_write(1'b1, 16'h0040, 2'b01, 1'b0);
        fork
            dev_frame(4, 1'b1, bits, inh, sb);
            wb_write(1'b0, 16'h003C, 2'b01, 1'b0);
        join
        check("midsend_busy", busy, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midsend_rst_outputs", {clk_oe, data_oe, busy, irq}, 4'b0000);
        wb_read(1'b1, rd);
        check("midsend_rst_csr", rd, 16'h0080);
        wb_read(1'b0, rd);
        check("midsend_rst_txdr", rd, 16'h0000);
        repeat (20) @(negedge clk);
        run_tx(8'hF4, 11, 1'b1, 16'h0080, "after_rst");

        // Randomized bytes with random acknowledge
        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_tx(rb, 11, rack, rack ? 16'h0080 : 16'h8080, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter for the KSM terminal. It sends command bytes to the keyboard, such as LED set (0xED) and reset (0xFF).
- It is the opposite direction of the existing PS/2 keyboard receiver.
- It is a Wishbone slave at 171004–171006 with a DL11-style ready/IE/interrupt model, and drives open-drain PS/2 clock/data enables.

Parameters:
- CLKFREQ, 50000000, wb_clk_i frequency in Hz.
- INHIBIT_US, 100, clock-low inhibit time before start.
- START_TO_US, 15000, maximum wait from clock release to first device falling edge.
- FRAME_TO_US, 2000, maximum time from first falling edge to ack edge.
- FILT, 8, glitch filter depth in samples.

Ports:
- wb_clk_i  in  1  system clock (single clock domain)
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_adr_i  in  16  address; only bit 1 decoded (0 = TXDR, 1 = TXCSR)
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe (pre-decoded by top-level)
- wb_we_i  in  1  write enable
- wb_sel_i  in  2  byte selects
- wb_ack_o  out  1  acknowledge
- irq  out  1  interrupt request to vectored interrupt controller
- iack  in  1  interrupt acknowledge pulse
- ps2_clk_i  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_i  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull clock low
- ps2_data_oe  out  1  1 = pull data low
- busy  out  1  1 while a frame is in progress; lets the receiver ignore line activity

Behaviour:

Reset (wb_rst_i high at a clock edge; also applies mid-operation)
- State = IDLE.
- ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0.
- READY = 1, IE = 0, ERR = 0, irq = 0, TXDR = 0, wb_ack_o = 0.

Wishbone
- wb_ack_o is registered: high for exactly one cycle, on the cycle after the first cycle with cyc & stb; low the following cycle even if stb is held.
- Reads return combinationally:
  - TXDR = {8'b0, last written byte}.
  - TXCSR = {ERR, 7'b0, READY, IE, 6'b0} (bit 15 = ERR, bit 7 = READY, bit 6 = IE).

Register writes
- Write TXDR with sel[0] = 1 while READY = 1: latch byte, clear ERR, READY → 0, busy → 1, enter INHIBIT the next cycle.
- Write TXDR while READY = 0: ignored, but still acked.
- Write TXCSR with sel[0] = 1: IE = dat[6]. Any TXCSR write with dat[15] = 0 clears ERR.

Line input conditioning
- ps2_clk_i and ps2_data_i each pass a 2-flop synchronizer, then a FILT-sample majority-free filter: the filtered value changes only after FILT equal consecutive samples.
- fall = filtered clock 1→0.

FSM (timer counts cycles; US values × CLKFREQ/1e6)
- INHIBIT: clk_oe = 1, data_oe = 0. After INHIBIT_US: data_oe = 1 (start bit), and next cycle clk_oe = 0 → START.
- START: wait for fall.
  - Timeout START_TO_US → ERR = 1, go to FINISH.
  - On fall: present d0 (data_oe = ~d0), n = 1, restart timer → SEND.
- SEND: on each fall, present the next bit: d1..d7 (n = 1..7), then odd parity (data_oe = ~(~^byte)), then stop (data_oe = 0) → ACK.
  - The timer is not restarted per bit; FRAME_TO_US covers the whole frame.
- ACK: on fall, sample filtered data.
  - 0 = ack OK. 1 = NACK → ERR = 1.
  - Then → WAITIDLE.
- WAITIDLE: wait until filtered clock = 1 and data = 1 → FINISH.
- FRAME_TO_US expiry in SEND, ACK, or WAITIDLE → ERR = 1, release both lines, → FINISH.
- FINISH: both oe = 0, busy = 0, READY = 1 → IDLE (one cycle).

Interrupt
- irq is set when:
  - FINISH is entered with IE = 1, or
  - a TXCSR write changes IE 0→1 while READY = 1.
- irq is cleared by any of: iack, writing IE = 0, starting a TXDR transmission, reset.
- If a set event and iack occur in the same cycle, the set wins.

Boundary cases
- fall during INHIBIT is ignored (the host is driving the clock).
- ps2_data_oe is changed only in the cycle after the fall that is detected.
- A TXDR write and a FINISH in the same cycle: the write is ignored (READY is still 0 that cycle).

Test Plan:
1. Write TXDR = 0x00ED; device model clocks at 12.5 kHz and acks.
   - clk_oe low for 5000 cycles.
   - Line bits after start: 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - Ack received → READY = 1, ERR = 0, TXCSR reads 0000200.
2. Send 0x00 and 0x01.
   - Parity observed is 1 and 0 respectively.
   - Second write issued while busy: ignored, TXDR still reads 0x0000 until the first frame ends.
3. IE = 1, send 0xFF with ack.
   - irq rises on FINISH; iack pulse clears it.
   - Writing IE 0→1 while idle re-raises irq.
4. Device never clocks (CLKFREQ = 1000000 for speed).
   - After 100 + 15000 cycles: ERR = 1, both oe = 0, READY = 1.
   - TXCSR = 0100200; a TXCSR write of 0 clears ERR.
5. Device holds data high at the 11th falling edge (NACK) → ERR = 1 after lines idle.
   - Device stops clocking after bit 4 → ERR = 1 at FRAME_TO_US; lines released.
6. Assert wb_rst_i mid-SEND.
   - Next cycle: both oe = 0, busy = 0, READY = 1, irq = 0.
   - A subsequent 0xF4 transmits correctly.
